// File: rtl/uart_rx_os.sv
`timescale 1ns/1ps
// uart_rx_os: 16x-oversampling UART receiver with majority vote, break detect and AXI-Stream output FIFO
module uart_rx_os #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop2,
  input  logic                  rx_wire,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [1:0]            m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  overrun,
  output logic                  break_det,
  output logic                  rx_busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t st_q;
  logic s1_q, rxs_q, s7_q, s8_q, p_q, perr_q, ferr_q, scnt_q, stop2_q, brk_q, ovr_q;
  logic [DIV_WIDTH-1:0] div_q, tcnt_q;
  logic [1:0] par_q;
  logic [3:0] os_q;
  logic [BW-1:0] bcnt_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH+1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic tick, dec, eob, maj, pen, last_stop, brk, fe, push, full, pop, wr;
  always_comb begin
    tick = st_q != IDLE && tcnt_q == div_q - DIV_WIDTH'(1);
    dec = tick && os_q == 4'd9;
    eob = tick && os_q == 4'd15;
    maj = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);
    pen = par_q == 2'd1 || par_q == 2'd2;
    last_stop = !stop2_q || scnt_q;
    brk = data_q == '0 && (!pen || !p_q) && !maj && (!stop2_q || ferr_q);
    fe = ferr_q | ~maj;
    push = st_q == STOP && dec && last_stop && !brk;
    full = cnt_q == (AW+1)'(FIFO_DEPTH);
    pop = m_axis_tvalid && m_axis_tready;
    wr = push && (!full || pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1_q, rxs_q} <= 2'b11;
    else {s1_q, rxs_q} <= {rx_wire, s1_q};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st_q <= IDLE;
      div_q <= DIV_WIDTH'(1);
      tcnt_q <= '0;
      par_q <= '0;
      stop2_q <= 1'b0;
      os_q <= '0;
      s7_q <= 1'b1;
      s8_q <= 1'b1;
      bcnt_q <= '0;
      data_q <= '0;
      p_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      scnt_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      brk_q <= 1'b0;
      if (st_q != IDLE) begin
        tcnt_q <= tick ? '0 : tcnt_q + DIV_WIDTH'(1);
        if (tick) os_q <= os_q + 4'd1;
      end
      if (tick && os_q == 4'd7) s7_q <= rxs_q;
      if (tick && os_q == 4'd8) s8_q <= rxs_q;
      case (st_q)
        IDLE: if (!rxs_q) begin
          st_q <= START;
          div_q <= cfg_div == '0 ? DIV_WIDTH'(1) : cfg_div;
          par_q <= cfg_parity;
          stop2_q <= cfg_stop2;
          tcnt_q <= '0;
          os_q <= '0;
          bcnt_q <= '0;
          scnt_q <= 1'b0;
          p_q <= 1'b0;
          perr_q <= 1'b0;
          ferr_q <= 1'b0;
        end
        START: if (dec && maj) st_q <= IDLE;
          else if (eob) st_q <= DATA;
        DATA: begin
          if (dec) data_q <= {maj, data_q[DATA_WIDTH-1:1]};
          if (eob) begin
            bcnt_q <= bcnt_q + BW'(1);
            if (bcnt_q == BW'(DATA_WIDTH-1)) st_q <= pen ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (dec) begin
            p_q <= maj;
            perr_q <= par_q == 2'd1 ? (^data_q) == maj : (^data_q) != maj;
          end
          if (eob) st_q <= STOP;
        end
        STOP: begin
          if (dec && !last_stop) ferr_q <= ~maj;
          if (eob) scnt_q <= 1'b1;
          if (dec && last_stop) begin
            st_q <= brk ? BREAK : IDLE;
            brk_q <= brk;
          end
        end
        BREAK: if (rxs_q) st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (wr) mem_q[wr_q] <= {perr_q, fe, data_q};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (wr) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
      ovr_q <= push && full && !pop;
    end
  assign m_axis_tvalid = cnt_q != '0;
  assign m_axis_tdata = m_axis_tvalid ? mem_q[rd_q][DATA_WIDTH-1:0] : '0;
  assign m_axis_tuser = m_axis_tvalid ? mem_q[rd_q][DATA_WIDTH+1:DATA_WIDTH] : '0;
  assign overrun = ovr_q;
  assign break_det = brk_q;
  assign rx_busy = st_q != IDLE;
endmodule

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
// tb_uart_rx_os: table-driven and directed checks of the oversampling UART receiver
module tb_uart_rx_os;
  logic clk = 0, rst = 1, rx_wire = 1, tready = 0, cfg_stop2 = 0;
  logic [15:0] cfg_div = 16'd4;
  logic [1:0] cfg_parity = 2'd0;
  logic [7:0] tdata;
  logic [1:0] tuser;
  logic tvalid, overrun, break_det, rx_busy;
  int cyc = 0, ov_cnt = 0, brk_cnt = 0, rise_cyc = 0;
  logic tv_prev = 0;
  int n_chk = 0, n_fail = 0, start_cyc = 0, o0, b0;
  typedef struct {
    logic [7:0] d;
    logic [1:0] par;
    logic p, stop2, s1, s2;
    logic [7:0] ed;
    logic [1:0] eu;
  } vec_t;
  vec_t tv [10];
  uart_rx_os dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .rx_wire(rx_wire), .m_axis_tdata(tdata), .m_axis_tuser(tuser), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .overrun(overrun), .break_det(break_det), .rx_busy(rx_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (tvalid && !tv_prev) rise_cyc = cyc;
    tv_prev = tvalid;
    if (overrun) ov_cnt = ov_cnt + 1;
    if (break_det) brk_cnt = brk_cnt + 1;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b, input int bp);
    rx_wire = b;
    cycles(bp);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic haspar, input logic p, input logic s1,
                            input logic hass2, input logic s2, input int bp);
    cycles(1);
    start_cyc = cyc;
    send_bit(1'b0, bp);
    for (int i = 0; i < 8; i++) send_bit(d[i], bp);
    if (haspar) send_bit(p, bp);
    send_bit(s1, bp);
    if (hass2) send_bit(s2, bp);
    send_bit(1'b1, bp);
  endtask
  task automatic wait_valid(input string nm);
    for (int i = 0; i < 3000 && !tvalid; i++) cycles(1);
    chk(nm, tvalid, 1);
  endtask
  task automatic pop();
    tready = 1;
    cycles(1);
    tready = 0;
  endtask
  task automatic expect_beat(input string nm, input logic [7:0] d, input logic [1:0] u);
    wait_valid({nm, "_valid"});
    chk({nm, "_data"}, tdata, d);
    chk({nm, "_user"}, tuser, u);
    pop();
    chk({nm, "_empty"}, tvalid, 0);
  endtask
  initial begin
    tv[0] = '{8'h3C, 2'd0, 0, 0, 1, 1, 8'h3C, 2'b00};
    tv[1] = '{8'h03, 2'd2, 1, 0, 1, 1, 8'h03, 2'b10};
    tv[2] = '{8'h03, 2'd2, 0, 0, 1, 1, 8'h03, 2'b00};
    tv[3] = '{8'h03, 2'd1, 0, 0, 1, 1, 8'h03, 2'b10};
    tv[4] = '{8'h80, 2'd1, 0, 0, 1, 1, 8'h80, 2'b00};
    tv[5] = '{8'h3C, 2'd0, 0, 1, 1, 0, 8'h3C, 2'b01};
    tv[6] = '{8'h55, 2'd0, 0, 0, 0, 1, 8'h55, 2'b01};
    tv[7] = '{8'hFF, 2'd3, 0, 0, 1, 1, 8'hFF, 2'b00};
    tv[8] = '{8'h00, 2'd2, 1, 0, 1, 1, 8'h00, 2'b10};
    tv[9] = '{8'h81, 2'd1, 1, 1, 1, 1, 8'h81, 2'b00};
    cycles(3);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_break", break_det, 0);
    chk("rst_busy", rx_busy, 0);
    rst = 0;
    cycles(5);
    send_frame(8'hA5, 0, 0, 1, 0, 1, 64);
    wait_valid("lat_valid");
    chk("lat_cycles", rise_cyc - start_cyc, 619);
    chk("lat_data", tdata, 8'hA5);
    chk("lat_user", tuser, 0);
    pop();
    for (int i = 0; i < 10; i++) begin
      cfg_parity = tv[i].par;
      cfg_stop2 = tv[i].stop2;
      send_frame(tv[i].d, tv[i].par == 2'd1 || tv[i].par == 2'd2, tv[i].p, tv[i].s1,
                 tv[i].stop2, tv[i].s2, 64);
      expect_beat($sformatf("vec%0d", i), tv[i].ed, tv[i].eu);
    end
    cfg_parity = 0;
    cfg_stop2 = 0;
    cycles(1);
    rx_wire = 0;
    cycles(16);
    rx_wire = 1;
    chk("glitch_busy", rx_busy, 1);
    cycles(48);
    chk("glitch_idle", rx_busy, 0);
    chk("glitch_novalid", tvalid, 0);
    send_frame(8'h5A, 0, 0, 1, 0, 1, 64);
    expect_beat("after_glitch", 8'h5A, 0);
    o0 = ov_cnt;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 0, 0, 1, 0, 1, 64);
    chk("ovr_none", ov_cnt - o0, 0);
    send_frame(8'h05, 0, 0, 1, 0, 1, 64);
    chk("ovr_once", ov_cnt - o0, 1);
    chk("stall_data0", tdata, 8'h01);
    cycles(50);
    chk("stall_data1", tdata, 8'h01);
    chk("stall_valid", tvalid, 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain%0d", i), tdata, 32'(i));
      pop();
    end
    chk("drain_empty", tvalid, 0);
    b0 = brk_cnt;
    cycles(1);
    rx_wire = 0;
    cycles(20 * 64);
    chk("brk_once", brk_cnt - b0, 1);
    chk("brk_nopush", tvalid, 0);
    chk("brk_busy", rx_busy, 1);
    rx_wire = 1;
    cycles(10);
    chk("brk_exit", rx_busy, 0);
    send_frame(8'h7E, 0, 0, 1, 0, 1, 64);
    expect_beat("after_brk", 8'h7E, 0);
    chk("brk_still_once", brk_cnt - b0, 1);
    fork
      send_frame(8'hC3, 0, 0, 1, 0, 1, 64);
      begin
        cycles(100);
        cfg_div = 16'd8;
      end
    join
    expect_beat("div_hold", 8'hC3, 0);
    cfg_div = 16'd0;
    send_frame(8'h96, 0, 0, 1, 0, 1, 16);
    expect_beat("div_zero", 8'h96, 0);
    cfg_div = 16'd4;
    send_frame(8'h11, 0, 0, 1, 0, 1, 64);
    wait_valid("pre_rst_valid");
    o0 = ov_cnt;
    b0 = brk_cnt;
    cycles(1);
    rx_wire = 0;
    cycles(200);
    chk("mid_busy", rx_busy, 1);
    rst = 1;
    #1;
    chk("mid_rst_busy", rx_busy, 0);
    chk("mid_rst_flush", tvalid, 0);
    cycles(3);
    rst = 0;
    cycles(11 * 64);
    chk("low_rel_break", brk_cnt - b0, 1);
    chk("low_rel_nopush", tvalid, 0);
    chk("low_rel_no_ovr", ov_cnt - o0, 0);
    rx_wire = 1;
    cycles(10);
    chk("low_rel_idle", rx_busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
